apb_cmd_master: RTL and testbench



---
 rtl/apb_cmd_pkg.sv | 20 ++
 rtl/apb_cmd_master.sv | 160 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_pkg.sv
// Shared types and defaults for the APB command master.
`ifndef CFG_APB_ADDR_WIDTH
`define CFG_APB_ADDR_WIDTH 32
`endif
`ifndef CFG_APB_DATA_WIDTH
`define CFG_APB_DATA_WIDTH 32
`endif

package apb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_cmd_state_e;

    localparam int APB_CMD_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB requester with a registered response.
// Optional ACCESS-phase timeout is built in when APB_CMD_MASTER_TIMEOUT_EN is defined.
`ifndef CFG_APB_ADDR_WIDTH
`define CFG_APB_ADDR_WIDTH 32
`endif
`ifndef CFG_APB_DATA_WIDTH
`define CFG_APB_DATA_WIDTH 32
`endif

// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | first APB cycle: psel=1, penable=0
// ACCESS | psel=1, penable=1 until pready (or timeout)
// RESP   | rsp_valid held until rsp_ready
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = `CFG_APB_ADDR_WIDTH,
    parameter int APB_DATA_WIDTH = `CFG_APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_CMD_TIMEOUT_DEFAULT
) (
    input  logic                      apb_pclk,
    input  logic                      apb_preset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      apb_psel,
    output logic                      apb_penable,
    output logic                      apb_pwrite,
    output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    output logic [APB_DATA_WIDTH-1:0] apb_pwdata,
    input  logic                      apb_pready,
    input  logic                      apb_pslverr,
    input  logic [APB_DATA_WIDTH-1:0] apb_prdata
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_cmd_master: TIMEOUT_CYCLES must be at least 2");
    end

    apb_cmd_state_e            state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    // Down-counter loaded in SETUP; terminal count marks the last allowed ACCESS cycle.
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_SETUP;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                tmo_cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            end
            ST_ACCESS: begin
                if (apb_pready) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = apb_pslverr;
                    rsp_rdata_d = (!pwrite_q && !apb_pslverr) ? apb_prdata : '0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    state_d       = ST_RESP;
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge apb_pclk) begin
        if (apb_preset) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign apb_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign apb_penable = (state_q == ST_ACCESS);
    assign rsp_valid   = (state_q == ST_RESP);
    assign apb_paddr   = paddr_q;
    assign apb_pwdata  = pwdata_q;
    assign apb_pwrite  = pwrite_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed plus randomized bench for apb_cmd_master against a transaction-level model.
`ifndef CFG_APB_ADDR_WIDTH
`define CFG_APB_ADDR_WIDTH 32
`endif
`ifndef CFG_APB_DATA_WIDTH
`define CFG_APB_DATA_WIDTH 32
`endif

module tb_apb_cmd_master;

    localparam int AW  = `CFG_APB_ADDR_WIDTH;
    localparam int DW  = `CFG_APB_DATA_WIDTH;
    localparam int TMO = 4;

    logic          apb_pclk = 1'b0;
    logic          apb_preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          apb_psel, apb_penable, apb_pwrite;
    logic [AW-1:0] apb_paddr;
    logic [DW-1:0] apb_pwdata;
    logic          apb_pready, apb_pslverr;
    logic [DW-1:0] apb_prdata;

    int vectors     = 0;
    int miscompares = 0;

    apb_cmd_master #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .apb_pclk   (apb_pclk),
        .apb_preset (apb_preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .apb_psel   (apb_psel),
        .apb_penable(apb_penable),
        .apb_pwrite (apb_pwrite),
        .apb_paddr  (apb_paddr),
        .apb_pwdata (apb_pwdata),
        .apb_pready (apb_pready),
        .apb_pslverr(apb_pslverr),
        .apb_prdata (apb_prdata)
    );

    always #5 apb_pclk = ~apb_pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level expectation: how many ACCESS cycles and what response.
    function automatic void model(input bit wr, input bit slverr, input logic [DW-1:0] rd,
                                  input int waits, output int acc, output bit tmo,
                                  output bit err, output logic [DW-1:0] rdata);
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        tmo = (waits + 1 > TMO);
`else
        tmo = 1'b0;
`endif
        acc   = tmo ? TMO : waits + 1;
        err   = tmo || slverr;
        rdata = (wr || err) ? '0 : rd;
    endfunction

    task automatic cycle();
        @(posedge apb_pclk);
        @(negedge apb_pclk);
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int waits, input bit slverr, input logic [DW-1:0] rd,
                           input int rdy_delay, input bit hold_valid);
        int            acc;
        bit            tmo, err;
        logic [DW-1:0] exp_rd;
        model(wr, slverr, rd, waits, acc, tmo, err, exp_rd);

        check("idle_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cycle();

        if (!hold_valid) cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        check("setup_psel", apb_psel, 1'b1);
        check("setup_penable", apb_penable, 1'b0);
        check("setup_cmd_ready", cmd_ready, 1'b0);
        check("setup_paddr", apb_paddr, addr);
        check("setup_pwrite", apb_pwrite, wr);
        check("setup_pwdata", apb_pwdata, wd);
        apb_pready  = 1'($urandom);
        apb_pslverr = 1'($urandom);
        apb_prdata  = DW'($urandom);
        cycle();

        for (int i = 0; i < acc; i++) begin
            check("access_psel", apb_psel, 1'b1);
            check("access_penable", apb_penable, 1'b1);
            check("access_paddr", apb_paddr, addr);
            check("access_pwdata", apb_pwdata, wd);
            check("access_rsp_valid", rsp_valid, 1'b0);
            apb_pready  = (i == acc - 1) && !tmo;
            apb_pslverr = apb_pready ? slverr : 1'($urandom);
            apb_prdata  = apb_pready ? rd : DW'($urandom);
            if (i == acc - 1 && rdy_delay == 0) begin
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
            end
            cycle();
        end

        apb_pready  = 1'($urandom);
        apb_pslverr = 1'($urandom);
        apb_prdata  = DW'($urandom);
        check("resp_valid", rsp_valid, 1'b1);
        check("resp_psel", apb_psel, 1'b0);
        check("resp_penable", apb_penable, 1'b0);
        check("resp_cmd_ready", cmd_ready, 1'b0);
        check("resp_err", rsp_err, err);
        check("resp_rdata", rsp_rdata, exp_rd);
        check("resp_timeout", rsp_timeout, tmo);

        for (int i = 0; i < rdy_delay; i++) begin
            cycle();
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            check("hold_psel", apb_psel, 1'b0);
            check("hold_err", rsp_err, err);
            check("hold_rdata", rsp_rdata, exp_rd);
        end
        if (rdy_delay > 0) begin
            rsp_ready = 1'b1;
            cmd_valid = 1'b0;
        end
        cycle();

        check("done_rsp_valid", rsp_valid, 1'b0);
        check("done_cmd_ready", cmd_ready, 1'b1);
        check("done_psel", apb_psel, 1'b0);
        rsp_ready  = 1'b0;
        apb_pready = 1'b0;
    endtask

    // Start a read, stall ACCESS for n cycles, then reset mid-transfer.
    task automatic abandon(input int n);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        cycle();
        cmd_valid  = 1'b0;
        apb_pready = 1'b0;
        cycle();
        for (int i = 1; i < n; i++) cycle();
        check("stall_psel", apb_psel, 1'b1);
        check("stall_penable", apb_penable, 1'b1);
        check("stall_rsp_valid", rsp_valid, 1'b0);
        apb_preset = 1'b1;
        rsp_ready  = 1'b1;
        cycle();
        apb_preset = 1'b0;
        check("rst_psel", apb_psel, 1'b0);
        check("rst_penable", apb_penable, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_paddr", apb_paddr, '0);
        for (int i = 0; i < 3; i++) begin
            apb_pready = 1'($urandom);
            cycle();
            check("post_rst_rsp_valid", rsp_valid, 1'b0);
            check("post_rst_psel", apb_psel, 1'b0);
        end
        rsp_ready  = 1'b0;
        apb_pready = 1'b0;
    endtask

    initial begin
        apb_preset  = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        apb_prdata  = '0;
        repeat (2) @(posedge apb_pclk);
        @(negedge apb_pclk);
        apb_preset = 1'b0;

        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rsp_timeout", rsp_timeout, 1'b0);
        check("reset_psel", apb_psel, 1'b0);
        check("reset_penable", apb_penable, 1'b0);
        check("reset_pwrite", apb_pwrite, 1'b0);
        check("reset_paddr", apb_paddr, '0);
        check("reset_pwdata", apb_pwdata, '0);
        check("reset_rsp_rdata", rsp_rdata, '0);

        run_txn(1'b1, AW'(32'h10), DW'(32'hA5), 0, 1'b0, DW'(32'h0), 0, 1'b0);
        run_txn(1'b0, AW'(32'h14), DW'(32'h0), 3, 1'b0, DW'(32'h3C), 1, 1'b0);
        run_txn(1'b0, AW'(32'h18), DW'(32'h0), 1, 1'b1, DW'(32'hFF), 0, 1'b0);
        run_txn(1'b1, AW'(32'h20), DW'(32'h5A), 0, 1'b0, DW'(32'h0), 5, 1'b1);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
        run_txn(1'b0, AW'(32'h24), DW'(32'h0), 20, 1'b0, DW'(32'h77), 0, 1'b0);
        run_txn(1'b1, AW'(32'h28), DW'(32'h11), TMO - 1, 1'b0, DW'(32'h0), 0, 1'b0);
`else
        abandon(100);
`endif
        abandon(2);

        for (int k = 0; k < 24; k++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 6)),
                    ($urandom_range(0, 3) == 0), DW'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
